// File: rtl/lenet_f2_pkg.sv
// Shared constants and tap tag type for the f2 feature-map RAM (read and write side).
package lenet_f2_pkg;

    localparam int unsigned IMG_W          = 14;
    localparam int unsigned IMG_H          = 14;
    localparam int unsigned K              = 5;
    localparam int unsigned DW             = 96;
    localparam int unsigned AW             = 10;
    localparam int unsigned OUT_W          = IMG_W - K + 1;
    localparam int unsigned OUT_H          = IMG_H - K + 1;
    localparam int unsigned TAPS_PER_WIN   = K * K;
    localparam int unsigned TAPS_PER_FRAME = OUT_W * OUT_H * TAPS_PER_WIN;
    localparam int unsigned KW             = $clog2(K);
    localparam int unsigned OCW            = $clog2(OUT_W);
    localparam int unsigned ORW            = $clog2(OUT_H);
    localparam int unsigned TAG_W          = 3;

    typedef struct packed {
        logic first;
        logic last;
        logic frame_last;
    } tap_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/f2_rd_fifo.sv
// Small circular buffer absorbing RAM read latency; head is registered storage, no fall-through.
module f2_rd_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 99,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/f2_window_reader.sv
// Walks every KxK window of the f2 map, issues RAM reads and streams tap words over valid/ready.
module f2_window_reader
    import lenet_f2_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] f2_raddr,
    output logic          f2_rd_en,
    input  logic [DW-1:0] f2_rdata,
    output logic [DW-1:0] win_data,
    output logic          win_valid,
    input  logic          win_ready,
    output logic          win_first,
    output logic          win_last,
    output logic          frame_last
);

    localparam int unsigned DEPTH = RD_LAT + 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned FW    = DW + TAG_W;

    rd_state_e        state, state_nxt;
    logic [KW-1:0]    kc, kr;
    logic [OCW-1:0]   ocol;
    logic [ORW-1:0]   orow;
    logic [AW-1:0]    win_base, row_base;
    logic [CW-1:0]    pend;
    logic             issue_c, pop_c, done_c;
    tap_tag_t         tag_c, head_tag;
    logic [RD_LAT-1:0] trk_vld;
    tap_tag_t         trk_tag [RD_LAT];
    logic [CW-1:0]    fifo_count;
    logic [FW-1:0]    fifo_head;

    // Tags of the tap about to be issued
    always_comb begin
        tag_c.first      = (kc == '0) && (kr == '0);
        tag_c.last       = (kc == KW'(K - 1)) && (kr == KW'(K - 1));
        tag_c.frame_last = tag_c.last && (ocol == OCW'(OUT_W - 1)) && (orow == ORW'(OUT_H - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (issue_c && tag_c.frame_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pop_c && head_tag.frame_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Credit rule: reads outstanding (in flight + buffered) never exceed buffer depth
    always_comb begin
        pop_c   = win_valid && win_ready;
        issue_c = 1'b0;
        done_c  = 1'b0;
        if (state == ST_RUN)   issue_c = (pend < CW'(DEPTH)) || pop_c;
        if (state == ST_DRAIN) done_c  = pop_c && head_tag.frame_last;
    end

    assign busy     = (state != ST_IDLE);
    assign f2_rd_en = issue_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            pend <= '0;
        end else begin
            done <= done_c;
            pend <= pend + CW'(issue_c) - CW'(pop_c);
        end
    end

    // Incremental address walk: kc, then kr (row stride), then window column, then window row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kc       <= '0;
            kr       <= '0;
            ocol     <= '0;
            orow     <= '0;
            win_base <= '0;
            row_base <= '0;
            f2_raddr <= '0;
        end else if (issue_c) begin
            if (kc != KW'(K - 1)) begin
                kc       <= kc + KW'(1);
                f2_raddr <= f2_raddr + AW'(1);
            end else if (kr != KW'(K - 1)) begin
                kc       <= '0;
                kr       <= kr + KW'(1);
                row_base <= row_base + AW'(IMG_W);
                f2_raddr <= row_base + AW'(IMG_W);
            end else begin
                kc <= '0;
                kr <= '0;
                if (tag_c.frame_last) begin
                    ocol     <= '0;
                    orow     <= '0;
                    win_base <= '0;
                    row_base <= '0;
                    f2_raddr <= '0;
                end else if (ocol != OCW'(OUT_W - 1)) begin
                    ocol     <= ocol + OCW'(1);
                    win_base <= win_base + AW'(1);
                    row_base <= win_base + AW'(1);
                    f2_raddr <= win_base + AW'(1);
                end else begin
                    ocol     <= '0;
                    orow     <= orow + ORW'(1);
                    win_base <= win_base + AW'(IMG_W - OUT_W + 1);
                    row_base <= win_base + AW'(IMG_W - OUT_W + 1);
                    f2_raddr <= win_base + AW'(IMG_W - OUT_W + 1);
                end
            end
        end
    end

    // In-flight tracker aligned with the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) trk_tag[i] <= '0;
        end else begin
            trk_vld[0] <= issue_c;
            trk_tag[0] <= tag_c;
            for (int i = 1; i < RD_LAT; i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_tag[i] <= trk_tag[i-1];
            end
        end
    end

    f2_rd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (trk_vld[RD_LAT-1]),
        .push_data ({f2_rdata, trk_tag[RD_LAT-1]}),
        .pop       (pop_c),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign win_valid  = (fifo_count != '0);
    assign head_tag   = tap_tag_t'(fifo_head[TAG_W-1:0]);
    assign win_data   = fifo_head[FW-1:TAG_W];
    assign win_first  = win_valid & head_tag.first;
    assign win_last   = win_valid & head_tag.last;
    assign frame_last = win_valid & head_tag.frame_last;

endmodule

// File: tb/tb_f2_window_reader.sv
// Scoreboard bench for f2_window_reader, RD_LAT=1 and RD_LAT=2 instances driven in lockstep.
module tb_f2_window_reader;

    typedef struct packed {
        logic [95:0] d;
        logic        f;
        logic        l;
        logic        fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        win_ready;
    logic        busy   [2];
    logic        done   [2];
    logic [9:0]  raddr  [2];
    logic        rd_en  [2];
    logic [95:0] rdata  [2];
    logic [95:0] wdata  [2];
    logic        wvalid [2];
    logic        wfirst [2];
    logic        wlast  [2];
    logic        flast  [2];
    logic [95:0] ram1_q;

    exp_t sb0[$];
    exp_t sb1[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t_start = 0;
    int   mode = 0;
    bit   full_rate = 1'b0;
    int   beats  [2];
    int   nfirst [2];
    int   nlast  [2];
    int   ndone  [2];
    bit   hold_v [2];
    exp_t hold_e [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: word[a] = a, latency 1 and 2
    always @(posedge clk) begin
        rdata[0] <= rd_en[0] ? 96'(raddr[0]) : {96{1'b1}};
        ram1_q   <= rd_en[1] ? 96'(raddr[1]) : {96{1'b1}};
        rdata[1] <= ram1_q;
    end

    f2_window_reader #(.RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
        .f2_raddr(raddr[0]), .f2_rd_en(rd_en[0]), .f2_rdata(rdata[0]),
        .win_data(wdata[0]), .win_valid(wvalid[0]), .win_ready(win_ready),
        .win_first(wfirst[0]), .win_last(wlast[0]), .frame_last(flast[0])
    );

    f2_window_reader #(.RD_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
        .f2_raddr(raddr[1]), .f2_rd_en(rd_en[1]), .f2_rdata(rdata[1]),
        .win_data(wdata[1]), .win_valid(wvalid[1]), .win_ready(win_ready),
        .win_first(wfirst[1]), .win_last(wlast[1]), .frame_last(flast[1])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sb_size(input int g);
        return (g == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t sb_pop(input int g);
        return (g == 0) ? sb0.pop_front() : sb1.pop_front();
    endfunction

    function automatic bit overflow(input int g);
        if (g == 0) return u_dut0.u_fifo.push && !u_dut0.u_fifo.pop && (u_dut0.u_fifo.count == 2'd2);
        return u_dut1.u_fifo.push && !u_dut1.u_fifo.pop && (u_dut1.u_fifo.count == 2'd3);
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int orow = 0; orow < 10; orow++)
            for (int ocol = 0; ocol < 10; ocol++)
                for (int kr = 0; kr < 5; kr++)
                    for (int kc = 0; kc < 5; kc++) begin
                        e.d  = 96'((orow + kr) * 14 + ocol + kc);
                        e.f  = (kr == 0) && (kc == 0);
                        e.l  = (kr == 4) && (kc == 4);
                        e.fl = e.l && (orow == 9) && (ocol == 9);
                        sb0.push_back(e);
                        sb1.push_back(e);
                    end
    endtask

    // Per-cycle monitor, sampled on the falling edge
    task automatic monitor();
        exp_t e, got;
        for (int g = 0; g < 2; g++) begin
            if (!rst_n) begin
                hold_v[g] = 1'b0;
                continue;
            end
            got = '{d: wdata[g], f: wfirst[g], l: wlast[g], fl: flast[g]};
            if (hold_v[g]) check($sformatf("hold[%0d]", g), {wvalid[g], got}, {1'b1, hold_e[g]});
            if (wvalid[g] && win_ready) begin
                if (full_rate && beats[g] == 0) check($sformatf("first_lat[%0d]", g), cyc - t_start, g + 2);
                if (sb_size(g) == 0) check($sformatf("extra_beat[%0d]", g), 1, 0);
                else begin
                    e = sb_pop(g);
                    check($sformatf("beat%0d[%0d]", beats[g], g), got, e);
                end
                beats[g]++;
                if (wfirst[g]) nfirst[g]++;
                if (wlast[g])  nlast[g]++;
            end
            hold_v[g] = wvalid[g] && !win_ready;
            hold_e[g] = got;
            if (overflow(g)) check($sformatf("overflow[%0d]", g), 1, 0);
            if (done[g]) begin
                ndone[g]++;
                check($sformatf("busy_at_done[%0d]", g), busy[g], 0);
                check($sformatf("sb_left[%0d]", g), sb_size(g), 0);
                check($sformatf("beats[%0d]", g), beats[g], 2500);
                check($sformatf("firsts[%0d]", g), nfirst[g], 100);
                check($sformatf("lasts[%0d]", g), nlast[g], 100);
                if (full_rate) check($sformatf("done_time[%0d]", g), cyc - t_start, g + 2 + 2500);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < 2; g++)
            check($sformatf("%s[%0d]", tag, g),
                  {raddr[g], rd_en[g], wvalid[g], wdata[g], wfirst[g], wlast[g], flast[g], busy[g], done[g]},
                  128'(0));
    endtask

    task automatic run_frame();
        push_frame();
        for (int g = 0; g < 2; g++) begin
            beats[g]  = 0;
            nfirst[g] = 0;
            nlast[g]  = 0;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t_start = cyc;
        for (int g = 0; g < 2; g++)
            check($sformatf("first_issue[%0d]", g), {busy[g], rd_en[g], raddr[g]}, {1'b1, 1'b1, 10'd0});
    endtask

    task automatic wait_done(input int n_exp);
        int i;
        for (i = 0; i < 8000 && !(ndone[0] >= n_exp && ndone[1] >= n_exp); i++) @(negedge clk);
        if (i >= 8000) check("done_timeout", 0, 1);
        repeat (10) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("ndone[%0d]", g), ndone[g], n_exp);
            check($sformatf("idle_after[%0d]", g), {busy[g], rd_en[g], wvalid[g]}, 3'b000);
        end
    endtask

    initial begin
        int i;
        rst_n = 1'b0;
        start = 1'b0;
        win_ready = 1'b0;
        for (int g = 0; g < 2; g++) begin
            ndone[g] = 0;
            beats[g] = 0;
            hold_v[g] = 1'b0;
        end
        fork
            forever begin
                @(negedge clk);
                monitor();
            end
            forever begin
                @(posedge clk);
                #1;
                if (mode == 0)      win_ready = 1'b1;
                else if (mode == 1) win_ready = 1'($urandom_range(0, 1));
            end
        join_none

        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;

        // Full rate frame
        mode = 0;
        full_rate = 1'b1;
        run_frame();
        wait_done(1);

        // Random backpressure with a start pulse while busy
        mode = 1;
        full_rate = 1'b0;
        run_frame();
        repeat (700) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(2);

        // Long stall right after a window's last tap
        mode = 0;
        run_frame();
        for (i = 0; i < 4000 && !(wvalid[0] && win_ready && wlast[0] && beats[0] > 700); i++) @(negedge clk);
        if (i >= 4000) check("stall_point_timeout", 0, 1);
        mode = 2;
        @(posedge clk); #1 win_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++)
            check($sformatf("stall_halt[%0d]", g), {rd_en[g], wvalid[g]}, 2'b01);
        repeat (15) @(posedge clk);
        #1 win_ready = 1'b1;
        mode = 0;
        @(negedge clk);
        check("resume_first", {wvalid[0], wfirst[0]}, 2'b11);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("resume_rate%0d", k), {wvalid[0], wvalid[1]}, 2'b11);
        end
        wait_done(3);

        // Asynchronous reset in mid-frame, then a clean restart
        full_rate = 1'b1;
        run_frame();
        for (i = 0; i < 4000 && beats[0] < 1200; i++) @(negedge clk);
        if (i >= 4000) check("reset_point_timeout", 0, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        sb0.delete();
        sb1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run_frame();
        wait_done(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/f2_window_reader.md
# f2_window_reader

Read-side engine for the f2 feature-map RAM (14×14 pixels, 6 channels × 16 bit packed per 96-bit word). On a start pulse it walks every 5×5 conv3 window over the 14×14 map, drives the RAM read address and streams the 25 tap words per window to the conv3 datapath over a valid/ready handshake. It absorbs the RAM's fixed read latency with a small credit-controlled buffer, so backpressure never loses or duplicates data.

## Interface
- IMG_W, 14, map width in pixels
- IMG_H, 14, map height in pixels
- K, 5, window edge (taps per window = K*K = 25)
- DW, 96, RAM word width
- AW, 10, RAM address width
- RD_LAT, 1, RAM read latency in cycles (supported: 1 or 2)
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: begin one frame pass
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after the final tap handshake
- f2_raddr  out  AW  RAM read address
- f2_rd_en  out  1  address valid this cycle (issue strobe)
- f2_rdata  in  DW  RAM read data, valid RD_LAT cycles after issue
- win_data  out  DW  tap word
- win_valid  out  1  tap word valid
- win_ready  in  1  consumer accepts when valid && ready
- win_first  out  1  tap 0 of a window (qualified by win_valid)
- win_last  out  1  tap 24 of a window
- frame_last  out  1  tap 24 of the final window

## Operation
- Idle until start while !busy; start during busy is ignored.
- Window order: out col (0..IMG_W-K) fastest, then out row (0..IMG_H-K): 10×10 = 100 windows, 2500 taps.
- Tap order inside window: kc fastest, then kr. Address = (orow+kr)*IMG_W + (ocol+kc), generated incrementally (base + row stride), no multiplier.
- Issue: f2_rd_en=1 with next address when buffer occupancy + in-flight reads < RD_LAT+1, or when a pop occurs this cycle. Stops after tap 2499 issued.
- In-flight tracker: RD_LAT-deep valid shift register carrying per-tap first/last/frame_last tags; at its output f2_rdata plus tags pushed into buffer (depth RD_LAT+1). Overflow is impossible by construction; the bench asserts it.
- Output = buffer head; pop on win_valid && win_ready. win_data and tags held stable while valid && !ready.
- done pulses the cycle after the frame_last handshake; busy drops the same cycle.
- Async reset mid-frame: all counters, tracker and buffer cleared; returns to idle; RAM contents untouched; a new start restarts at window (0,0).

## Timing
- Reset values: f2_raddr=0, f2_rd_en=0, win_valid=0, win_data=0, win_first=0, win_last=0, frame_last=0, busy=0, done=0.
- start sampled at edge T: busy=1 and first issue (addr 0) at T+1; first win_valid at T+1+RD_LAT+1.
- Ready held high: one tap per cycle, no bubbles between windows or rows; done at T+RD_LAT+2+2500.
- Ready low for N cycles: issue halts within one cycle of buffer+in-flight reaching RD_LAT+1; throughput resumes at 1/cycle the cycle ready returns.

## Structure
- Package lenet_f2_pkg: IMG_W, IMG_H, K, DW, AW, tap-count constant, and a tap tag struct {first, last, frame_last}; shared with the f2 write-side address generator.
- One sub-module: f2_rd_fifo (parameterised depth RD_LAT+1, DW+3 bits wide, count output, fall-through not required).
- Top: state machine IDLE → RUN (issuing) → DRAIN (all issued, buffer not empty) → IDLE with done.

## Test plan
- RAM model with word[a] = a; start, ready=1 -> window 0 taps 0,1,2,3,4,14,…,56..60; window 1 starts at 1; last window base 135, last tap 195; frame_last only there.
- Full frame ready=1, RD_LAT=1 and 2 -> exactly 2500 beats, 100 win_first/win_last, done at T+RD_LAT+2+2500, busy low after.
- Random ready (50%) -> identical 2500-word sequence, no drops/duplicates, data stable while stalled, buffer never overflows.
- Ready low 20 cycles right after a win_last -> next beat is the new window's tap 0 with win_first=1.
- start pulsed mid-frame -> ignored, sequence unchanged, single done.
- rst_n low at tap 1200 -> all outputs to reset values immediately; new start yields tap 0 address 0.
